// File: rtl/axi_interconnect_crossbar_mresp_merge.sv
// Response-path merge for the AXI crossbar.
// Round-robin arbitration across NUM_MASTER response sources. A source that
// wins with a non-last beat keeps the grant until its last beat is accepted.
// Each output beat is {payload, source_index}, registered once, so a new beat
// can be loaded in the same cycle the held beat drains.
//
// Handshake: a beat moves on any interface only in a cycle where valid and
// ready are both high. A valid that has been raised is not withdrawn, and its
// data is held stable until ready is seen. s_resp_ready may depend on
// resp_ready and on the arbitration result. resp_valid and resp_info come
// straight from registers.
module axi_interconnect_crossbar_mresp_merge #(
  parameter int NUM_MASTER     = 2,
  parameter int WIDTH_RESPINFO = 48,
  parameter int WIDTH_IDX      = (NUM_MASTER <= 2) ? 1 : $clog2(NUM_MASTER),
  parameter int U_DLY          = 1
) (
  input  logic                                 clk_sys,
  input  logic                                 rst_n,
  input  logic [NUM_MASTER*WIDTH_RESPINFO-1:0] s_resp_info,
  input  logic [NUM_MASTER-1:0]                s_resp_last,
  input  logic [NUM_MASTER-1:0]                s_resp_valid,
  output logic [NUM_MASTER-1:0]                s_resp_ready,
  output logic [WIDTH_RESPINFO+WIDTH_IDX-1:0]  resp_info,
  output logic                                 resp_last,
  output logic                                 resp_valid,
  input  logic                                 resp_ready
);

  // Number of index codes. Source vectors are zero-padded up to this size,
  // so indexing them with any WIDTH_IDX value stays in range.
  localparam int NUM_SLOT = 1 << WIDTH_IDX;

  // Reject parameter sets the index field cannot represent.
  if (NUM_MASTER < 1 || NUM_MASTER > 16 || U_DLY < 0 || NUM_SLOT < NUM_MASTER) begin : g_bad_param
    $error("axi_interconnect_crossbar_mresp_merge: illegal parameter set");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t                      state;
  logic [WIDTH_IDX-1:0]        grant;
  logic [WIDTH_IDX-1:0]        rr_ptr;

  logic [NUM_SLOT-1:0]         valid_pad;
  logic [NUM_SLOT-1:0]         last_pad;
  logic [WIDTH_RESPINFO-1:0]   pay_pad [NUM_SLOT];

  logic                        hi_found;
  logic [WIDTH_IDX-1:0]        hi_idx;
  logic [WIDTH_IDX-1:0]        lo_idx;
  logic [WIDTH_IDX-1:0]        arb_idx;

  logic [WIDTH_IDX-1:0]        sel;
  logic                        sel_valid;
  logic                        sel_last;
  logic                        out_free;
  logic                        take;
  logic [WIDTH_IDX-1:0]        next_ptr;

  // Unpack the flat source buses into zero-padded per-slot views.
  always_comb begin
    valid_pad = '0;
    last_pad  = '0;
    for (int i = 0; i < NUM_SLOT; i++) begin
      pay_pad[i] = '0;
    end
    for (int i = 0; i < NUM_MASTER; i++) begin
      valid_pad[i] = s_resp_valid[i];
      last_pad[i]  = s_resp_last[i];
      pay_pad[i]   = s_resp_info[i*WIDTH_RESPINFO +: WIDTH_RESPINFO];
    end
  end

  // Round-robin pick: the lowest requester at or above rr_ptr wins; if there
  // is none, the lowest requester overall wins (wrap-around).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_MASTER - 1; i >= 0; i--) begin
      if (s_resp_valid[i]) begin
        lo_idx = WIDTH_IDX'(i);
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = WIDTH_IDX'(i);
        end
      end
    end
    arb_idx = hi_found ? hi_idx : lo_idx;
  end

  // Source selection. In LOCK only the granted source is considered.
  always_comb begin
    sel       = (state == ST_LOCK) ? grant : arb_idx;
    sel_valid = (state == ST_LOCK) ? valid_pad[grant] : (|s_resp_valid);
    sel_last  = last_pad[sel];
    out_free  = ~resp_valid | resp_ready;
    take      = out_free & sel_valid;
    next_ptr  = (sel == WIDTH_IDX'(NUM_MASTER - 1)) ? '0 : sel + WIDTH_IDX'(1);
  end

  // Ready goes only to the selected source, and only when the output can load.
  always_comb begin
    s_resp_ready = '0;
    for (int i = 0; i < NUM_MASTER; i++) begin
      if (take && (int'(sel) == i)) begin
        s_resp_ready[i] = 1'b1;
      end
    end
  end

  // Arbiter state and the registered output stage.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      resp_info  <= '0;
      resp_last  <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      if (take) begin
        resp_info  <= {pay_pad[sel], sel};
        resp_last  <= sel_last;
        resp_valid <= 1'b1;
        if (sel_last) begin
          rr_ptr <= next_ptr;
          state  <= ST_IDLE;
        end else begin
          grant  <= sel;
          state  <= ST_LOCK;
        end
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule
